// File: rtl/cache_mem_arbiter_if.sv
// Line-granular port bundle for cache_mem_arbiter: icache, dcache and memory sides.
// The arbiter uses the slave modport; the surrounding caches and memory use master.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // Handshake: a requester holds x_read/x_write (and its addr/wdata) until it sees the
  // one-cycle x_resp; the arbiter holds m_read/m_write until the one-cycle m_resp.
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-granular memory port between icache and dcache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the dcache wins ties.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d == 0 means the icache was served last, so the first tie goes to the dcache.
  logic last_d;
  assign grant_d = d_req & (~i_req | ~last_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (grant_d) begin
              state   <= BUSY_D;
              addr_q  <= {bus.d_addr[ADDR_W-1:5], 5'b0};
              wdata_q <= bus.d_wdata;
              // A simultaneous read and write-back is served as the write-back.
              write_q <= bus.d_write;
              read_q  <= ~bus.d_write;
            end else begin
              state   <= BUSY_I;
              addr_q  <= {bus.i_addr[ADDR_W-1:5], 5'b0};
              wdata_q <= '0;
              write_q <= 1'b0;
              read_q  <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_d <= grant_d;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.m_resp) begin
            state   <= DONE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        DONE: begin
          // One dead cycle so a requester that saw its resp can drop before re-arbitration.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_read  = read_q;
  assign bus.m_write = write_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.i_resp  = bus.m_resp & (state == BUSY_I);
  assign bus.d_resp  = bus.m_resp & (state == BUSY_D);
  assign bus.i_rdata = (state == BUSY_I) ? bus.m_rdata : '0;
  assign bus.d_rdata = (state == BUSY_D) ? bus.m_rdata : '0;

  assign state_dbg = state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vectors, tie/reset sequences and
// randomized traffic against a request-level model of the arbitration rules.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];

  // model state: which cache was served last (reset value: icache)
  bit last_i = 1'b1;

  typedef struct {
    logic          i_read;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    int            lat;
    logic [LW-1:0] rdata;
    bit            exp_i;
    logic          exp_rd;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_pick_i(input bit ip, input bit dp);
    if (!dp) return 1'b1;
    if (!ip) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_i;
`else
    return 1'b0;
`endif
  endfunction

  // Run one transaction for the predicted winner; expected m_addr comes from exp_q.
  task automatic serve(input bit exp_i, input logic exp_rd, input logic exp_wr,
                       input logic [LW-1:0] exp_wdata, input int exp_wait, input int lat,
                       input logic [LW-1:0] rdata, input bit drop);
    int w;
    logic [AW-1:0] ea;
    w  = 0;
    ea = exp_q.pop_front();
    while (!(bus.m_read || bus.m_write) && w < 6) begin
      tick();
      w++;
    end
    chk("grant_wait", w, exp_wait);
    chk("m_read", bus.m_read, exp_rd);
    chk("m_write", bus.m_write, exp_wr);
    chk("m_addr", bus.m_addr, ea);
    if (exp_wr) chk("m_wdata", bus.m_wdata, exp_wdata);
    if (drop) begin
      if (exp_i) bus.i_addr = $urandom();
      else begin
        bus.d_addr  = $urandom();
        bus.d_wdata = {8{$urandom()}};
      end
    end
    for (int k = 1; k < lat; k++) begin
      tick();
      chk("hold_addr", bus.m_addr, ea);
      chk("hold_op", {bus.m_read, bus.m_write}, {exp_rd, exp_wr});
      if (exp_wr) chk("hold_wdata", bus.m_wdata, exp_wdata);
      chk("early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    end
    bus.m_resp  = 1'b1;
    bus.m_rdata = rdata;
    #1;
    chk("i_resp", bus.i_resp, exp_i);
    chk("d_resp", bus.d_resp, !exp_i);
    chk("i_rdata", bus.i_rdata, exp_i ? rdata : '0);
    chk("d_rdata", bus.d_rdata, exp_i ? '0 : rdata);
    tick();
    bus.m_resp  = 1'b0;
    bus.m_rdata = {8{$urandom()}};
    #1;
    chk("done_quiet", {bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}, 4'b0000);
    chk("done_rdata", bus.i_rdata | bus.d_rdata, '0);
    last_i = exp_i;
    if (drop) begin
      tick();
      if (exp_i) bus.i_read = 1'b0;
      else begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ip, dp, dw, win_i;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dwd;
    int            op;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h60, 32'h0, '0, 5, {32{8'hA5}},
                1'b1, 1'b1, 1'b0, 32'h60, '0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h1234, {8{32'hDEADBEEF}}, 3, {8{32'h0}},
                1'b0, 1'b0, 1'b1, 32'h1220, {8{32'hDEADBEEF}}};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'hABCD_EF7F, {8{32'h1357_9BDF}}, 2, {8{32'h5A5A_0F0F}},
                1'b0, 1'b0, 1'b1, 32'hABCD_EF60, {8{32'h1357_9BDF}}};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0045, {8{32'hFFFF_0000}}, 1, {8{32'hC3C3_3C3C}},
                1'b0, 1'b1, 1'b0, 32'h8000_0040, '0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, '0, 4, {8{32'h0123_4567}},
                1'b1, 1'b1, 1'b0, 32'hFFFF_FFE0, '0};

    rst         = 1'b0;
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_resp  = 1'b0;
    tick();
    tick();
    chk("rst_op", {bus.m_read, bus.m_write}, 2'b00);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst_addr", bus.m_addr, '0);
    chk("rst_wdata", bus.m_wdata, '0);
    chk("rst_state", state_dbg, 2'd0);
    rst    = 1'b1;
    last_i = 1'b1;
    tick();

    // stray m_resp in IDLE
    bus.m_resp  = 1'b1;
    bus.m_rdata = {LW{1'b1}};
    #1;
    chk("stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("stray_rdata", bus.i_rdata | bus.d_rdata, '0);
    tick();
    bus.m_resp = 1'b0;
    chk("stray_state", state_dbg, 2'd0);
    chk("stray_op", {bus.m_read, bus.m_write}, 2'b00);

    // tie, twice, from a fresh reset
    for (int t = 0; t < 2; t++) begin
      bus.i_read = 1'b1;
      bus.i_addr = 32'h100 + t;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h200 + t;
      win_i = model_pick_i(1'b1, 1'b1);
      exp_q.push_back(win_i ? 32'h100 : 32'h200);
      serve(win_i, 1'b1, 1'b0, '0, 1, 2, {8{$urandom()}}, 1'b1);
      exp_q.push_back(win_i ? 32'h200 : 32'h100);
      serve(!win_i, 1'b1, 1'b0, '0, 1, 2, {8{$urandom()}}, 1'b1);
      tick();
    end

`ifndef ARB_ROUND_ROBIN_EN
    // dcache held over three transactions starves the icache
    bus.i_read = 1'b1;
    bus.i_addr = 32'h440;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h880;
    for (int t = 0; t < 3; t++) begin
      exp_q.push_back(32'h880);
      serve(1'b0, 1'b1, 1'b0, '0, (t == 0) ? 1 : 2, 2, {8{$urandom()}}, t == 2);
    end
    exp_q.push_back(32'h440);
    serve(1'b1, 1'b1, 1'b0, '0, 1, 1, {8{$urandom()}}, 1'b1);
    tick();
`endif

    for (int v = 0; v < 5; v++) begin
      bus.i_read  = vecs[v].i_read;
      bus.i_addr  = vecs[v].i_addr;
      bus.d_read  = vecs[v].d_read;
      bus.d_write = vecs[v].d_write;
      bus.d_addr  = vecs[v].d_addr;
      bus.d_wdata = vecs[v].d_wdata;
      exp_q.push_back(vecs[v].exp_addr);
      serve(vecs[v].exp_i, vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_wdata, 1,
            vecs[v].lat, vecs[v].rdata, 1'b1);
      tick();
      chk("no_regrant", {bus.m_read, bus.m_write}, 2'b00);
    end

    // reset in the middle of a dcache read
    bus.d_read = 1'b1;
    bus.d_addr = 32'h340;
    tick();
    chk("rst_mid_busy", bus.m_read, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_op", {bus.m_read, bus.m_write}, 2'b00);
    chk("rst_mid_addr", bus.m_addr, '0);
    chk("rst_mid_state", state_dbg, 2'd0);
    bus.m_resp = 1'b1;
    #1;
    chk("rst_mid_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    bus.m_resp = 1'b0;
    bus.d_read = 1'b0;
    #1;
    rst    = 1'b1;
    last_i = 1'b1;
    tick();
    tick();
    chk("rst_after_op", {bus.m_read, bus.m_write}, 2'b00);
    chk("rst_after_state", state_dbg, 2'd0);

    // random traffic against the request-level model
    ip = 1'b0;
    dp = 1'b0;
    dw = 1'b0;
    ia = '0;
    da = '0;
    dwd = '0;
    for (int r = 0; r < 40; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1;
        ia = $urandom();
        bus.i_read = 1'b1;
        bus.i_addr = ia;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp  = 1'b1;
        op  = $urandom_range(0, 2);
        dw  = (op != 0);
        da  = $urandom();
        dwd = {8{$urandom()}};
        bus.d_read  = (op != 1);
        bus.d_write = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
      end
      if (!ip && !dp) begin
        ip = 1'b1;
        ia = $urandom();
        bus.i_read = 1'b1;
        bus.i_addr = ia;
      end
      win_i = model_pick_i(ip, dp);
      exp_q.push_back((win_i ? ia : da) & ~32'h1F);
      serve(win_i, win_i ? 1'b1 : !dw, !win_i && dw, dwd, 1, $urandom_range(1, 4),
            {8{$urandom()}}, 1'b1);
      if (win_i) ip = 1'b0;
      else dp = 1'b0;
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
